// File: rtl/conv_sweep_ctrl_if.sv
// rtl/conv_sweep_ctrl_if.sv - handshake and address bus between the sweep controller and the conv core
//
// Purpose: groups the start/stall handshake and the per-step address/flag set.
// Ports (signals):
//   start, stall                     driven by master (core/host side)
//   busy, done, step_valid           controller status
//   in_addr [AW], k_addr [KW], out_addr [AW], ch_idx [CW]
//   tap_valid, first_tap, last_tap   per-step flags
// Modports: master (drives start/stall), slave (the controller).
interface conv_sweep_ctrl_if #(
    parameter int AW = 10,
    parameter int KW = 10,
    parameter int CH = 64
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic          step_valid;
    logic [AW-1:0] in_addr;
    logic [KW-1:0] k_addr;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] ch_idx;
    logic          tap_valid;
    logic          first_tap;
    logic          last_tap;

    modport master (
        output start, stall,
        input  busy, done, step_valid, in_addr, k_addr, out_addr, ch_idx,
               tap_valid, first_tap, last_tap
    );

    modport slave (
        input  start, stall,
        output busy, done, step_valid, in_addr, k_addr, out_addr, ch_idx,
               tap_valid, first_tap, last_tap
    );
endinterface

// File: rtl/conv_sweep_ctrl.sv
// rtl/conv_sweep_ctrl.sv - loop-nest sequencer for the 3x3 convolution core
//
// Purpose: on start, walks (m, n, mk, nk, ck) with ck fastest, issuing one
// step per unstalled cycle, then waits PIPE_LAT cycles and pulses done.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous reset, active-high
//   bus    conv_sweep_ctrl_if.slave: start/stall in; busy, done, step_valid,
//          in_addr, k_addr, out_addr, ch_idx, tap_valid, first_tap, last_tap out
module conv_sweep_ctrl #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int CH       = 64,
    parameter int PIPE_LAT = 8,
    parameter int AW       = 10,
    parameter int KW       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_sweep_ctrl_if.slave   bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = ($clog2(PIPE_LAT + 1) > 0) ? $clog2(PIPE_LAT + 1) : 1;

    localparam logic [CW-1:0] CK_MAX = CW'(CH - 1);
    localparam logic [XW-1:0] N_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] M_MAX  = YW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ck_q, ck_d;
    logic [1:0]    nk_q, nk_d;
    logic [1:0]    mk_q, mk_d;
    logic [XW-1:0] n_q, n_d;
    logic [YW-1:0] m_q, m_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          busy_q, done_q;
    logic [AW-1:0] in_addr_q, in_addr_d;
    logic [KW-1:0] k_addr_q, k_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [CW-1:0] ch_idx_q, ch_idx_d;
    logic          tap_q, tap_d;
    logic          first_q, first_d;
    logic          last_q, last_d;

    logic ck_last, nk_last, mk_last, n_last, m_last, final_step, run_d;

    assign ck_last    = (ck_q == CK_MAX);
    assign nk_last    = (nk_q == 2'd2);
    assign mk_last    = (mk_q == 2'd2);
    assign n_last     = (n_q == N_MAX);
    assign m_last     = (m_q == M_MAX);
    assign final_step = ck_last && nk_last && mk_last && n_last && m_last;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        ck_d    = ck_q;
        nk_d    = nk_q;
        mk_d    = mk_q;
        n_d     = n_q;
        m_d     = m_q;

        case (state_q)
            S_IDLE: begin
                ck_d = '0;
                nk_d = '0;
                mk_d = '0;
                n_d  = '0;
                m_d  = '0;
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall) begin
                    // Odometer carry chain; after the final step every digit
                    // wraps, so the counters are already zero for the next sweep.
                    if (ck_last) begin
                        ck_d = '0;
                        if (nk_last) begin
                            nk_d = '0;
                            if (mk_last) begin
                                mk_d = '0;
                                if (n_last) begin
                                    n_d = '0;
                                    m_d = m_last ? '0 : m_q + YW'(1);
                                end else begin
                                    n_d = n_q + XW'(1);
                                end
                            end else begin
                                mk_d = mk_q + 2'd1;
                            end
                        end else begin
                            nk_d = nk_q + 2'd1;
                        end
                    end else begin
                        ck_d = ck_q + CW'(1);
                    end
                    if (final_step) begin
                        state_d = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
                        drain_d = DW'(PIPE_LAT);
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q <= DW'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next counter values so the registered
        // address set always matches the step presented while in RUN; outside
        // RUN they read zero.
        run_d      = (state_d == S_RUN);
        in_addr_d  = run_d ? AW'(IMG_W * int'(m_d) + int'(n_d)) : '0;
        out_addr_d = run_d ? AW'(IMG_W * int'(m_d) + int'(n_d) + IMG_W + 1
                                 - IMG_W * int'(mk_d) - int'(nk_d)) : '0;
        k_addr_d   = run_d ? KW'((3 * int'(mk_d) + int'(nk_d)) * CH + int'(ck_d)) : '0;
        ch_idx_d   = run_d ? ck_d : '0;
        tap_d      = run_d && !((m_d == M_MAX && mk_d == 2'd0) ||
                                (m_d == '0    && mk_d == 2'd2) ||
                                (n_d == N_MAX && nk_d == 2'd0) ||
                                (n_d == '0    && nk_d == 2'd2));
        first_d    = run_d && (mk_d == 2'd0) && (nk_d == 2'd0) && (ck_d == '0);
        last_d     = run_d && (mk_d == 2'd2) && (nk_d == 2'd2) && (ck_d == CK_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            drain_q    <= '0;
            ck_q       <= '0;
            nk_q       <= '0;
            mk_q       <= '0;
            n_q        <= '0;
            m_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_addr_q  <= '0;
            k_addr_q   <= '0;
            out_addr_q <= '0;
            ch_idx_q   <= '0;
            tap_q      <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            ck_q       <= ck_d;
            nk_q       <= nk_d;
            mk_q       <= mk_d;
            n_q        <= n_d;
            m_q        <= m_d;
            busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
            in_addr_q  <= in_addr_d;
            k_addr_q   <= k_addr_d;
            out_addr_q <= out_addr_d;
            ch_idx_q   <= ch_idx_d;
            tap_q      <= tap_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.step_valid = (state_q == S_RUN) && !bus.stall;
    assign bus.in_addr    = in_addr_q;
    assign bus.k_addr     = k_addr_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.ch_idx     = ch_idx_q;
    assign bus.tap_valid  = tap_q;
    assign bus.first_tap  = first_q;
    assign bus.last_tap   = last_q;
endmodule

// File: tb/tb_conv_sweep_ctrl.sv
// tb/tb_conv_sweep_ctrl.sv - self-checking bench for conv_sweep_ctrl
module tb_conv_sweep_ctrl;
    localparam int W        = 4;
    localparam int H        = 4;
    localparam int CH       = 2;
    localparam int PIPE_LAT = 8;
    localparam int AW       = 10;
    localparam int KW       = 10;
    localparam int TOTAL    = W * H * 9 * CH;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int   m_mode = M_IDLE;
    int   m_step = 0;
    int   m_ef   = 0;
    int   gcyc   = 0;

    conv_sweep_ctrl_if #(.AW(AW), .KW(KW), .CH(CH)) bus ();

    conv_sweep_ctrl #(
        .IMG_W(W), .IMG_H(H), .CH(CH), .PIPE_LAT(PIPE_LAT), .AW(AW), .KW(KW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decompose a linear step number into the loop nest and apply the address rules.
    task automatic exp_step(input int k, output int ia, output int ka, output int oa,
                            output int ci, output int tv, output int ft, output int lt);
        int ck, nk, mk, n, m;
        ck = k % CH;
        nk = (k / CH) % 3;
        mk = (k / (3 * CH)) % 3;
        n  = (k / (9 * CH)) % W;
        m  = k / (9 * CH * W);
        ia = W * m + n;
        ka = (3 * mk + nk) * CH + ck;
        oa = (W * m + n + W + 1 - W * mk - nk) & ((1 << AW) - 1);
        ci = ck;
        tv = ((m == H - 1 && mk == 0) || (m == 0 && mk == 2) ||
              (n == W - 1 && nk == 0) || (n == 0 && nk == 2)) ? 0 : 1;
        ft = (mk == 0 && nk == 0 && ck == 0) ? 1 : 0;
        lt = (mk == 2 && nk == 2 && ck == CH - 1) ? 1 : 0;
    endtask

    // Reference timeline: which step is presented and when done is due.
    always @(posedge clk) begin
        gcyc++;
        if (rst) begin
            m_mode = M_IDLE;
            m_step = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (bus.start) begin m_mode = M_RUN; m_step = 0; end
                M_RUN:   if (!bus.stall) begin
                             if (m_step == TOTAL - 1) begin m_mode = M_DRAIN; m_ef = gcyc; end
                             else m_step++;
                         end
                M_DRAIN: if (gcyc - m_ef == PIPE_LAT) m_mode = M_DONE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always begin
        int ia, ka, oa, ci, tv, ft, lt;
        @(negedge clk);
        #2;
        if (chk_en) begin
            if (m_mode == M_RUN) exp_step(m_step, ia, ka, oa, ci, tv, ft, lt);
            else begin ia = 0; ka = 0; oa = 0; ci = 0; tv = 0; ft = 0; lt = 0; end
            chk("busy",       32'(bus.busy), (m_mode == M_RUN || m_mode == M_DRAIN) ? 1 : 0);
            chk("done",       32'(bus.done), (m_mode == M_DONE) ? 1 : 0);
            chk("step_valid", 32'(bus.step_valid), (m_mode == M_RUN && !bus.stall) ? 1 : 0);
            chk("in_addr",    32'(bus.in_addr), ia);
            chk("k_addr",     32'(bus.k_addr), ka);
            chk("out_addr",   32'(bus.out_addr), oa);
            chk("ch_idx",     32'(bus.ch_idx), ci);
            chk("tap_valid",  32'(bus.tap_valid), tv);
            chk("first_tap",  32'(bus.first_tap), ft);
            chk("last_tap",   32'(bus.last_tap), lt);
            if (m_mode == M_RUN && !bus.stall) begin
                case (m_step)
                    0: begin
                        chk("s0_in",  32'(bus.in_addr), 0);
                        chk("s0_k",   32'(bus.k_addr), 0);
                        chk("s0_out", 32'(bus.out_addr), 5);
                        chk("s0_first", 32'(bus.first_tap), 1);
                    end
                    1: begin
                        chk("s1_in",  32'(bus.in_addr), 0);
                        chk("s1_k",   32'(bus.k_addr), 1);
                        chk("s1_out", 32'(bus.out_addr), 5);
                    end
                    2: begin
                        chk("s2_k",   32'(bus.k_addr), 2);
                        chk("s2_out", 32'(bus.out_addr), 4);
                    end
                    4:  chk("s4_tap", 32'(bus.tap_valid), 0);
                    6: begin
                        chk("s6_k",   32'(bus.k_addr), 6);
                        chk("s6_out", 32'(bus.out_addr), 1);
                    end
                    17: chk("s17_last", 32'(bus.last_tap), 1);
                    default: ;
                endcase
            end
        end
    end

    // Runs one sweep from a start pulse. lat is the cycle index (1 = first cycle
    // after the start edge) in which done is seen; post counts busy/step_valid
    // cycles in the 10 cycles after done.
    task automatic sweep(input int stall_at, input int rst_at, input bit poke,
                         output int nsteps, output int lat, output int post);
        int cyc, stalls_left, tail;
        bit seen_done;
        nsteps = 0; lat = 0; post = 0; cyc = 0; stalls_left = 5; tail = 0; seen_done = 0;
        bus.start = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            bus.start = poke && !seen_done && (cyc == 50);
            if (rst) begin
                rst = 1'b0;
                break;
            end
            if (stall_at >= 0 && nsteps == stall_at && stalls_left > 0) begin
                bus.stall = 1'b1;
                stalls_left--;
            end else begin
                bus.stall = 1'b0;
            end
            if (rst_at >= 0 && nsteps == rst_at) rst = 1'b1;
            #1;
            if (seen_done) begin
                tail++;
                if (bus.busy || bus.step_valid) post++;
                if (tail == 10) break;
            end else begin
                if (bus.step_valid) nsteps++;
                if (bus.done) begin
                    seen_done = 1'b1;
                    lat = cyc;
                    if (poke) bus.start = 1'b1;
                end
            end
            if (cyc > 2000) begin
                tests++;
                fails++;
                $display("FAIL sweep_timeout: cyc=%0d limit=2000", cyc);
                break;
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        int ns, lat, post;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_busy",  32'(bus.busy), 0);
        chk("idle_done",  32'(bus.done), 0);
        chk("idle_sv",    32'(bus.step_valid), 0);
        chk("idle_in",    32'(bus.in_addr), 0);
        chk("idle_out",   32'(bus.out_addr), 0);
        chk("idle_k",     32'(bus.k_addr), 0);

        sweep(-1, -1, 1'b1, ns, lat, post);
        chk("sweep1_steps", 32'(ns), 288);
        chk("sweep1_done_cycle", 32'(lat), 297);
        chk("sweep1_post_busy", 32'(post), 0);

        sweep(100, -1, 1'b0, ns, lat, post);
        chk("stall_steps", 32'(ns), 288);
        chk("stall_done_cycle", 32'(lat), 302);

        sweep(-1, 150, 1'b0, ns, lat, post);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_in",    32'(bus.in_addr), 0);
        chk("rst_out",   32'(bus.out_addr), 0);
        chk("rst_tap",   32'(bus.tap_valid), 0);
        chk("rst_sv",    32'(bus.step_valid), 0);

        sweep(-1, -1, 1'b0, ns, lat, post);
        chk("restart_steps", 32'(ns), 288);
        chk("restart_done_cycle", 32'(lat), 297);
        chk("restart_post_busy", 32'(post), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_sweep_ctrl.md
# conv_sweep_ctrl

Sequencing controller for the 3x3 convolution core. On a start pulse it walks the full (row, column, kernel-row, kernel-column, channel) loop nest and issues one step per unstalled cycle: input-BRAM, kernel-BRAM and output-BRAM addresses plus border and tap flags. After the last step it waits out the core's pipeline latency, then pulses done. It takes over the free-running address generation and `en` gating that the core does today.

## Interface
Parameters:
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- CH, 64, channels per kernel tap
- PIPE_LAT, 8, cycles from a step's issue until its accumulated result is written to the output BRAM
- AW, 10, input/output BRAM address width (IMG_W*IMG_H <= 2^AW)
- KW, 10, kernel BRAM address width (9*CH <= 2^KW)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (despite the name)
- start  in  1  begin a sweep; sampled only in IDLE
- stall  in  1  hold the sweep; no step issued while high
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the sweep and drain are complete
- step_valid  out  1  current address set is a new step, to be consumed this cycle
- in_addr  out  AW  input BRAM address = IMG_W*m + n
- k_addr  out  KW  kernel BRAM address = (3*mk + nk)*CH + ck
- out_addr  out  AW  output BRAM address = IMG_W*m + n + IMG_W + 1 - IMG_W*mk - nk, modulo 2^AW
- ch_idx  out  log2(CH)  current channel ck
- tap_valid  out  1  target output pixel (m+1-mk, n+1-nk) lies inside the image
- first_tap  out  1  mk==0 && nk==0 && ck==0
- last_tap  out  1  mk==2 && nk==2 && ck==CH-1

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 moves to RUN. All loop counters are cleared.
  - RUN: each edge with stall=0 advances the counters.
    - Order, fastest first: ck (0..CH-1), nk (0..2), mk (0..2), n (0..IMG_W-1), m (0..IMG_H-1).
    - Each counter wraps to 0 and carries into the next.
    - When the final step (m=IMG_H-1, n=IMG_W-1, mk=nk=2, ck=CH-1) is consumed with stall=0, the state moves to DRAIN.
  - DRAIN: a counter loaded with PIPE_LAT decrements every cycle and ignores stall. On reaching 0 the state moves to DONE.
  - DONE: lasts one cycle, then IDLE.
- Outputs:
  - Address and flag outputs are registered from the counters. They hold their values while stalled.
  - step_valid = (state==RUN) && !stall (combinational).
  - tap_valid = 0 when any of these hold: (m==IMG_H-1 && mk==0), (m==0 && mk==2), (n==IMG_W-1 && nk==0), (n==0 && nk==2). Otherwise 1.
  - When tap_valid=0, out_addr may wrap modulo 2^AW. Consumers ignore it in that case.
- Total steps per sweep = IMG_H*IMG_W*9*CH, which is 589824 at the defaults.
- Control corner cases:
  - start while busy or during DONE is ignored and not queued.
  - Reset in any state returns to IDLE next edge and clears all counters.
- Reset values: busy=0, done=0, step_valid=0, every address/index/flag output 0.

## Timing
- start=1 at edge E0: state=RUN after E0, step_valid=1 (if stall=0), step 0 addresses on the outputs. busy rises after E0.
- One step per unstalled cycle; zero bubbles in RUN.
- Final step consumed at edge Ef: DRAIN for PIPE_LAT cycles after Ef. done=1 in the following cycle, with busy=0 in that same cycle.
- Unstalled sweep: done asserted exactly 1 + total_steps + PIPE_LAT cycles after the start edge.
- Each stalled RUN cycle delays done by exactly one cycle.
- stall in IDLE or DRAIN has no effect.

## Test plan
All scenarios use IMG_W=IMG_H=4, CH=2, PIPE_LAT=8, so 288 steps per sweep.
- Reset/idle: assert rst_n 2 cycles, hold start=0 for 20 cycles -> busy, done, step_valid, all addresses stay 0.
- Step count: single start pulse, stall=0 -> exactly 288 step_valid cycles, done at cycle 297 after the start edge (1+288+8), busy low that cycle, done high for 1 cycle only.
- Address sequence, first steps:
  - Steps 0,1: in_addr=0, k_addr=0,1, out_addr=5, first_tap=1 on step 0.
  - Step 2: k_addr=2, out_addr=4.
  - Step 4 (nk=2): tap_valid=0.
  - Step 6 (mk=1, nk=0): k_addr=6, out_addr=1.
  - Step 17: last_tap=1.
- Stall: raise stall for 5 cycles at step 100 -> outputs hold step 100 values, step_valid=0, still 288 total steps, done 5 cycles later (cycle 302).
- Reset mid-run at step 150 -> IDLE and all outputs 0 next edge. A fresh start restarts at step 0 and completes in 297 cycles.
- Start during busy and during the done cycle -> ignored: no second sweep, busy low after done.
